// File: rtl/osc_phase_accum_if.sv
// osc_phase_accum_if: sweep control, pitch capture and phase stream of osc_phase_accum.
interface osc_phase_accum_if #(
    parameter int V_WIDTH  = 3,
    parameter int O_WIDTH  = 2,
    parameter int OE_WIDTH = 1,
    parameter int PHASE_W  = 32
);
    logic                                sample_tick;
    logic                                note_on;
    logic [V_WIDTH-1:0]                  cur_key_adr;
    logic [23:0]                         osc_pitch_val;
    logic [V_WIDTH+O_WIDTH+OE_WIDTH-1:0] xxxx;
    logic [PHASE_W-1:0]                  phase_out;
    logic [V_WIDTH+O_WIDTH-1:0]          phase_slot;
    logic                                phase_valid;
    logic                                sweep_busy;
    logic                                overrun;

    modport master (
        output sample_tick, note_on, cur_key_adr, osc_pitch_val,
        input  xxxx, phase_out, phase_slot, phase_valid, sweep_busy, overrun
    );

    modport slave (
        input  sample_tick, note_on, cur_key_adr, osc_pitch_val,
        output xxxx, phase_out, phase_slot, phase_valid, sweep_busy, overrun
    );
endinterface

// File: rtl/osc_phase_accum.sv
// osc_phase_accum: sweeps every voice x oscillator slot per sample_tick, captures the pitch increment
// after the pitch_control latency and streams the accumulated phase with per-voice hard key sync.
module osc_phase_accum #(
    parameter int VOICES    = 8,
    parameter int V_OSC     = 4,
    parameter int V_WIDTH   = 3,
    parameter int O_WIDTH   = 2,
    parameter int OE_WIDTH  = 1,
    parameter int PITCH_LAT = 2,
    parameter int PHASE_W   = 32
) (
    input logic              sCLK_XVXENVS,
    input logic              reset,
    osc_phase_accum_if.slave bus
);
    localparam int S_WIDTH = V_WIDTH + O_WIDTH;
    localparam int SLOTS   = VOICES * V_OSC;
    localparam int D_WIDTH = $clog2(PITCH_LAT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [S_WIDTH-1:0]   cnt;
    logic [D_WIDTH-1:0]   dcnt;
    logic                 start, last;
    logic [S_WIDTH-1:0]   tag [PITCH_LAT];
    logic [PITCH_LAT-1:0] tag_v;
    logic [PHASE_W-1:0]   phase_ram [SLOTS];
    logic [VOICES-1:0]    sync_pend;
    logic                 sync_now;
    logic [S_WIDTH-1:0]   u_slot;
    logic [V_WIDTH-1:0]   u_voice;
    logic                 u_v, u_first, u_last, u_sync;
    logic [PHASE_W-1:0]   phase_new;
    logic [PHASE_W-1:0]   phase_out_q;
    logic [S_WIDTH-1:0]   phase_slot_q;
    logic                 phase_valid_q, overrun_q;

    assign start = state == IDLE && bus.sample_tick;
    assign last  = cnt == S_WIDTH'(SLOTS - 1);

    always_ff @(posedge sCLK_XVXENVS or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;

    always_comb
        state_nxt = start ? ISSUE :
                    (state == ISSUE && last) ? DRAIN :
                    (state == DRAIN && dcnt == D_WIDTH'(PITCH_LAT)) ? IDLE : state;

    always_comb begin
        bus.sweep_busy = state != IDLE;
        bus.xxxx       = {cnt, OE_WIDTH'(0)};
    end

    // The tag line mirrors the pitch_control pipeline so each increment meets its own slot.
    always_ff @(posedge sCLK_XVXENVS or posedge reset)
        if (reset) begin
            cnt   <= '0;
            dcnt  <= '0;
            tag_v <= '0;
            for (int i = 0; i < PITCH_LAT; i++) tag[i] <= '0;
        end else begin
            cnt      <= start ? '0 : (state == ISSUE && !last) ? cnt + S_WIDTH'(1) : cnt;
            dcnt     <= state == DRAIN ? dcnt + D_WIDTH'(1) : '0;
            tag[0]   <= cnt;
            tag_v[0] <= state == ISSUE;
            for (int i = 1; i < PITCH_LAT; i++) begin
                tag[i]   <= tag[i-1];
                tag_v[i] <= tag_v[i-1];
            end
        end

    assign u_slot  = tag[PITCH_LAT-1];
    assign u_v     = tag_v[PITCH_LAT-1];
    assign u_voice = u_slot[S_WIDTH-1:O_WIDTH];
    assign u_first = u_slot[O_WIDTH-1:0] == '0;
    assign u_last  = u_slot[O_WIDTH-1:0] == O_WIDTH'(V_OSC - 1);
    // Later oscillators reuse the decision latched at oscillator 0 so a voice never half-syncs.
    assign u_sync    = u_first ? sync_pend[u_voice] : sync_now;
    assign phase_new = (u_sync ? '0 : phase_ram[u_slot]) + PHASE_W'(bus.osc_pitch_val);

    always_ff @(posedge sCLK_XVXENVS or posedge reset)
        if (reset) for (int i = 0; i < SLOTS; i++) phase_ram[i] <= '0;
        else if (u_v) phase_ram[u_slot] <= phase_new;

    always_ff @(posedge sCLK_XVXENVS or posedge reset)
        if (reset) begin
            sync_pend <= '0;
            sync_now  <= 1'b0;
        end else begin
            if (u_v && u_first) sync_now <= sync_pend[u_voice];
            for (int i = 0; i < VOICES; i++)
                if (bus.note_on && bus.cur_key_adr == V_WIDTH'(i)) sync_pend[i] <= 1'b1;
                else if (u_v && u_last && u_sync && u_voice == V_WIDTH'(i)) sync_pend[i] <= 1'b0;
        end

    always_ff @(posedge sCLK_XVXENVS or posedge reset)
        if (reset) begin
            phase_out_q   <= '0;
            phase_slot_q  <= '0;
            phase_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            phase_valid_q <= u_v;
            if (u_v) begin
                phase_out_q  <= phase_new;
                phase_slot_q <= u_slot;
            end
            if (bus.sample_tick && state != IDLE) overrun_q <= 1'b1;
        end

    assign bus.phase_out   = phase_out_q;
    assign bus.phase_slot  = phase_slot_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_osc_phase_accum.sv
// tb_osc_phase_accum: directed sweeps checking accumulation, wrap, key sync, overrun and reset behaviour.
module tb_osc_phase_accum;
    logic        const_clk = 1'b0;
    logic        reset = 1'b1;
    int          vec = 0, mis = 0;
    int          pcyc = 0, t0 = 0, nv = 0, busy_cnt = 0, first_at = -1;
    logic [31:0] got [32];
    logic [4:0]  order [32];

    osc_phase_accum_if bus ();

    osc_phase_accum dut (
        .sCLK_XVXENVS(const_clk),
        .reset       (reset),
        .bus         (bus)
    );

    always #5 const_clk = ~const_clk;

    always @(posedge const_clk) pcyc <= pcyc + 1;

    always @(negedge const_clk) begin
        if (bus.sweep_busy) busy_cnt++;
        if (bus.phase_valid) begin
            if (nv == 0) first_at = pcyc - t0;
            if (nv < 32) order[nv] = bus.phase_slot;
            got[bus.phase_slot] = bus.phase_out;
            nv++;
        end
    end

    task automatic do_reset();
        @(posedge const_clk); #1;
        reset = 1'b1;
        bus.sample_tick = 1'b0;
        bus.note_on = 1'b0;
        @(posedge const_clk); #1;
        reset = 1'b0;
    endtask

    // One sweep; tick_at/non_at inject a sample_tick/note_on that many clocks after the sweep starts.
    task automatic run_sweep(input int tick_at, input int non_at, input logic [2:0] key);
        int k;
        @(posedge const_clk); #1;
        nv = 0;
        busy_cnt = 0;
        first_at = -1;
        for (int s = 0; s < 32; s++) got[s] = 32'hDEAD_BEEF;
        bus.sample_tick = 1'b1;
        @(posedge const_clk); #1;
        t0 = pcyc;
        bus.sample_tick = 1'b0;
        k = 1;
        while (bus.sweep_busy && k < 60) begin
            bus.sample_tick = k == tick_at;
            bus.note_on = k == non_at;
            bus.cur_key_adr = key;
            @(posedge const_clk); #1;
            k++;
        end
        bus.sample_tick = 1'b0;
        bus.note_on = 1'b0;
        vec++;
        if (bus.sweep_busy !== 1'b0) begin
            mis++;
            $display("FAIL sweep_timeout busy=%b after %0d clocks, required 0", bus.sweep_busy, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge const_clk);
        @(negedge const_clk);
        vec++; if (bus.xxxx !== 6'd0) begin mis++; $display("FAIL reset_xxxx got %h required 00", bus.xxxx); end
        vec++; if (bus.phase_out !== 32'd0) begin mis++; $display("FAIL reset_phase_out got %h required 0", bus.phase_out); end
        vec++; if (bus.phase_slot !== 5'd0) begin mis++; $display("FAIL reset_phase_slot got %h required 0", bus.phase_slot); end
        vec++; if (bus.phase_valid !== 1'b0) begin mis++; $display("FAIL reset_phase_valid got %b required 0", bus.phase_valid); end
        vec++; if (bus.sweep_busy !== 1'b0) begin mis++; $display("FAIL reset_sweep_busy got %b required 0", bus.sweep_busy); end
        vec++; if (bus.overrun !== 1'b0) begin mis++; $display("FAIL reset_overrun got %b required 0", bus.overrun); end
        @(posedge const_clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge const_clk);
        vec++; if (bus.sweep_busy !== 1'b0) begin mis++; $display("FAIL idle_busy got %b required 0", bus.sweep_busy); end
    endtask

    task automatic test_single_sweep();
        int errs = 0;
        bus.osc_pitch_val = 24'h000100;
        run_sweep(-1, -1, 3'd0);
        vec++; if (nv !== 32) begin mis++; $display("FAIL single_count got %0d valids required 32", nv); end
        vec++; if (first_at !== 3) begin mis++; $display("FAIL single_latency got %0d clocks required 3", first_at); end
        vec++; if (busy_cnt !== 35) begin mis++; $display("FAIL single_busy got %0d clocks required 35", busy_cnt); end
        for (int i = 0; i < 32; i++) if (order[i] !== 5'(i)) errs++;
        vec++; if (errs != 0) begin mis++; $display("FAIL single_order got %0d slots out of order required 0", errs); end
        for (int s = 0; s < 32; s++) begin
            vec++;
            if (got[s] !== 32'h100) begin mis++; $display("FAIL single_phase slot %0d got %h required 00000100", s, got[s]); end
        end
        vec++; if (bus.xxxx !== 6'd62) begin mis++; $display("FAIL idle_xxxx_hold got %0d required 62", bus.xxxx); end
        vec++; if (bus.overrun !== 1'b0) begin mis++; $display("FAIL single_overrun got %b required 0", bus.overrun); end
    endtask

    task automatic test_accumulate();
        repeat (3) run_sweep(-1, -1, 3'd0);
        vec++; if (nv !== 32) begin mis++; $display("FAIL accum_count got %0d required 32", nv); end
        for (int s = 0; s < 32; s++) begin
            vec++;
            if (got[s] !== 32'h400) begin mis++; $display("FAIL accum_phase slot %0d got %h required 00000400", s, got[s]); end
        end
    endtask

    task automatic test_sync();
        logic [31:0] e;
        do_reset();
        bus.osc_pitch_val = 24'h000100;
        repeat (3) run_sweep(-1, -1, 3'd0);
        @(posedge const_clk); #1;
        bus.note_on = 1'b1;
        bus.cur_key_adr = 3'd2;
        @(posedge const_clk); #1;
        bus.note_on = 1'b0;
        run_sweep(-1, -1, 3'd0);
        for (int s = 0; s < 32; s++) begin
            e = (s / 4 == 2) ? 32'h100 : 32'h400;
            vec++;
            if (got[s] !== e) begin mis++; $display("FAIL sync_first slot %0d got %h required %h", s, got[s], e); end
        end
        // note_on for voice 5 lands on its oscillator-0 update
        run_sweep(-1, 23, 3'd5);
        for (int s = 0; s < 32; s++) begin
            e = (s / 4 == 2) ? 32'h200 : 32'h500;
            vec++;
            if (got[s] !== e) begin mis++; $display("FAIL sync_osc0_late slot %0d got %h required %h", s, got[s], e); end
        end
        // note_on for voice 5 lands on its oscillator-3 clear
        run_sweep(-1, 26, 3'd5);
        for (int s = 0; s < 32; s++) begin
            e = (s / 4 == 5) ? 32'h100 : (s / 4 == 2) ? 32'h300 : 32'h600;
            vec++;
            if (got[s] !== e) begin mis++; $display("FAIL sync_deferred slot %0d got %h required %h", s, got[s], e); end
        end
        run_sweep(-1, -1, 3'd0);
        for (int s = 0; s < 32; s++) begin
            e = (s / 4 == 5) ? 32'h100 : (s / 4 == 2) ? 32'h400 : 32'h700;
            vec++;
            if (got[s] !== e) begin mis++; $display("FAIL sync_set_wins slot %0d got %h required %h", s, got[s], e); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.osc_pitch_val = 24'hFFFFFF;
        repeat (256) run_sweep(-1, -1, 3'd0);
        bus.osc_pitch_val = 24'h000080;
        run_sweep(-1, -1, 3'd0);
        vec++; if (got[5] !== 32'hFFFF_FF80) begin mis++; $display("FAIL wrap_preload got %h required ffffff80", got[5]); end
        bus.osc_pitch_val = 24'h000100;
        run_sweep(-1, -1, 3'd0);
        vec++; if (got[5] !== 32'h0000_0080) begin mis++; $display("FAIL wrap_slot5 got %h required 00000080", got[5]); end
        vec++; if (got[31] !== 32'h0000_0080) begin mis++; $display("FAIL wrap_slot31 got %h required 00000080", got[31]); end
    endtask

    task automatic test_overrun();
        int n0;
        do_reset();
        bus.osc_pitch_val = 24'h000100;
        run_sweep(10, -1, 3'd0);
        vec++; if (bus.overrun !== 1'b1) begin mis++; $display("FAIL overrun_flag got %b required 1", bus.overrun); end
        vec++; if (nv !== 32) begin mis++; $display("FAIL overrun_count got %0d required 32", nv); end
        vec++; if (busy_cnt !== 35) begin mis++; $display("FAIL overrun_busy got %0d required 35", busy_cnt); end
        n0 = nv;
        repeat (40) @(posedge const_clk);
        #1;
        vec++; if (nv !== n0) begin mis++; $display("FAIL overrun_no_second got %0d valids required %0d", nv, n0); end
        run_sweep(-1, -1, 3'd0);
        vec++; if (bus.overrun !== 1'b1) begin mis++; $display("FAIL overrun_sticky got %b required 1", bus.overrun); end
        vec++; if (got[17] !== 32'h200) begin mis++; $display("FAIL overrun_phase got %h required 00000200", got[17]); end
    endtask

    task automatic test_drain_edge();
        do_reset();
        bus.osc_pitch_val = 24'h000100;
        run_sweep(35, -1, 3'd0);
        vec++; if (bus.overrun !== 1'b1) begin mis++; $display("FAIL drain_overrun got %b required 1", bus.overrun); end
        @(negedge const_clk);
        vec++; if (bus.sweep_busy !== 1'b0) begin mis++; $display("FAIL drain_no_start got %b required 0", bus.sweep_busy); end
        vec++; if (nv !== 32) begin mis++; $display("FAIL drain_count got %0d required 32", nv); end
    endtask

    task automatic test_reset_mid();
        bus.osc_pitch_val = 24'h000100;
        @(posedge const_clk); #1;
        bus.sample_tick = 1'b1;
        @(posedge const_clk); #1;
        bus.sample_tick = 1'b0;
        repeat (14) @(posedge const_clk);
        #1;
        vec++; if (bus.phase_valid !== 1'b1) begin mis++; $display("FAIL mid_active got %b required 1", bus.phase_valid); end
        reset = 1'b1;
        #1;
        vec++; if (bus.sweep_busy !== 1'b0) begin mis++; $display("FAIL mid_busy got %b required 0", bus.sweep_busy); end
        vec++; if (bus.phase_valid !== 1'b0) begin mis++; $display("FAIL mid_valid got %b required 0", bus.phase_valid); end
        vec++; if (bus.phase_out !== 32'd0) begin mis++; $display("FAIL mid_phase_out got %h required 0", bus.phase_out); end
        vec++; if (bus.xxxx !== 6'd0) begin mis++; $display("FAIL mid_xxxx got %h required 0", bus.xxxx); end
        vec++; if (bus.overrun !== 1'b0) begin mis++; $display("FAIL mid_overrun got %b required 0", bus.overrun); end
        @(posedge const_clk); #1;
        reset = 1'b0;
        bus.osc_pitch_val = 24'h000123;
        run_sweep(-1, -1, 3'd0);
        vec++; if (nv !== 32) begin mis++; $display("FAIL mid_count got %0d required 32", nv); end
        for (int s = 0; s < 32; s++) begin
            vec++;
            if (got[s] !== 32'h123) begin mis++; $display("FAIL mid_phase slot %0d got %h required 00000123", s, got[s]); end
        end
    endtask

    initial begin
        bus.sample_tick = 1'b0;
        bus.note_on = 1'b0;
        bus.cur_key_adr = 3'd0;
        bus.osc_pitch_val = 24'd0;
        test_reset();
        test_single_sweep();
        test_accumulate();
        test_sync();
        test_wrap();
        test_overrun();
        test_drain_edge();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
